// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM sequencing the 8-bit multicycle datapath
module multicycle_control #(
  parameter int OPW = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [OPW-1:0] Opcode,
  input  logic           Zero,
  output logic           EscPC,
  output logic [1:0]     OrigPC,
  output logic           IouD,
  output logic           LeMem,
  output logic           EscMem,
  output logic           EscIR,
  output logic           EscReg,
  output logic           MemParaReg,
  output logic           ULAFonteA,
  output logic [1:0]     ULAFonteB,
  output logic [1:0]     ULAOp,
  output logic           Halted,
  output logic [3:0]     Estado
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    WB_R   = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    WB_MEM = 4'd6,
    MEM_WR = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    HALT   = 4'd10
  } state_t;
  localparam logic [OPW-1:0] OP_OR   = OPW'(3);
  localparam logic [OPW-1:0] OP_LW   = OPW'(4);
  localparam logic [OPW-1:0] OP_SW   = OPW'(5);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(7);
  localparam logic [OPW-1:0] OP_HALT = OPW'(15);
  state_t state, next;
  assign Estado = state;
  // state register; reset wins over any pending transition
  always_ff @(posedge clock)
    state <= reset ? FETCH : next;
  // next-state: opcode only matters in DECODE and ADDR, unused encodings fall back to FETCH
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:  next = DECODE;
      DECODE: next = (Opcode <= OP_OR) ? EXEC_R :
                     (Opcode == OP_LW || Opcode == OP_SW) ? ADDR :
                     (Opcode == OP_BEQ) ? BRANCH :
                     (Opcode == OP_JMP) ? JUMP :
                     (Opcode == OP_HALT) ? HALT : FETCH;
      EXEC_R: next = WB_R;
      ADDR:   next = (Opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD: next = WB_MEM;
      HALT:   next = HALT;
      default: next = FETCH;
    endcase
  end
  // Moore output decode (Zero gates EscPC in BRANCH); reset masks every write/read enable
  always_comb begin
    EscPC = 1'b0;
    OrigPC = 2'b00;
    IouD = 1'b0;
    LeMem = 1'b0;
    EscMem = 1'b0;
    EscIR = 1'b0;
    EscReg = 1'b0;
    MemParaReg = 1'b0;
    ULAFonteA = 1'b0;
    ULAFonteB = 2'b00;
    ULAOp = 2'b00;
    Halted = 1'b0;
    case (state)
      FETCH: begin
        LeMem = 1'b1;
        EscIR = 1'b1;
        ULAFonteB = 2'b01;
        EscPC = 1'b1;
      end
      DECODE: ULAFonteB = 2'b10;
      EXEC_R: begin
        ULAFonteA = 1'b1;
        ULAOp = 2'b10;
      end
      WB_R: EscReg = 1'b1;
      ADDR: begin
        ULAFonteA = 1'b1;
        ULAFonteB = 2'b10;
      end
      MEM_RD: begin
        IouD = 1'b1;
        LeMem = 1'b1;
      end
      WB_MEM: begin
        EscReg = 1'b1;
        MemParaReg = 1'b1;
      end
      MEM_WR: begin
        IouD = 1'b1;
        EscMem = 1'b1;
      end
      BRANCH: begin
        ULAFonteA = 1'b1;
        ULAOp = 2'b01;
        OrigPC = 2'b01;
        EscPC = Zero;
      end
      JUMP: begin
        OrigPC = 2'b10;
        EscPC = 1'b1;
      end
      HALT: Halted = 1'b1;
      default: ;
    endcase
    if (reset) begin
      EscPC = 1'b0;
      EscIR = 1'b0;
      EscMem = 1'b0;
      EscReg = 1'b0;
      LeMem = 1'b0;
    end
  end
endmodule
